// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one single-port word memory between an instruction-fetch port (I,
// read-only) and a data port (D, read/write). D has fixed priority. A streak
// counter forces an I grant once D has won MAX_D_STREAK times in a row while I
// waits. Each grant completes in one cycle and is answered by a one-cycle ack.
//
// Build option: define ARB_STATS_EN to add saturating grant/conflict counters
// (stat_i_grants, stat_d_grants, stat_conflicts).
module mem_port_arbiter #(
    parameter int IDX_W        = 5,
    parameter int MAX_D_STREAK = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_ack,
    output logic [31:0]      i_rdata,

    input  logic             d_req,
    input  logic             d_wen,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,

    output logic             mem_wen,
    output logic [IDX_W-1:0] mem_a,
    output logic [31:0]      mem_d,
    input  logic [31:0]      mem_q
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      stat_i_grants,
    output logic [15:0]      stat_d_grants,
    output logic [15:0]      stat_conflicts
`endif
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    grant_t     grant;
    logic       i_elig;
    logic       d_elig;
    logic [3:0] streak;

    // Byte-offset and high address bits never select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:IDX_W+2], i_addr[1:0],
                                d_addr[31:IDX_W+2], d_addr[1:0]};

    // Eligibility, grant choice and memory drive for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        mem_wen = 1'b0;
        mem_a   = '0;
        mem_d   = '0;
        grant   = GNT_NONE;

        // A port in its ack cycle sits out, so it never double-issues.
        i_elig = i_req && !i_ack;
        d_elig = d_req && !d_ack;

        if (d_elig && (!i_elig || streak != STREAK_MAX)) begin
            grant = GNT_D;
        end else if (i_elig) begin
            grant = GNT_I;
        end

        case (grant)
            GNT_D: begin
                mem_a   = d_addr[IDX_W+1:2];
                // Writes are blocked combinationally while reset is held.
                mem_wen = d_wen && !rst;
                mem_d   = d_wdata;
            end
            GNT_I: begin
                mem_a = i_addr[IDX_W+1:2];
            end
            default: ;
        endcase
    end

    // Ack pulses and read-data capture for the port granted this cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= (grant == GNT_I);
            d_ack <= (grant == GNT_D);
            if (grant == GNT_I) begin
                i_rdata <= mem_q;
            end
            if (grant == GNT_D) begin
                d_rdata <= d_wen ? d_wdata : mem_q;
            end
        end
    end

    // Streak of D grants won while I is waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (!i_req || grant == GNT_I) begin
            streak <= '0;
        end else if (grant == GNT_D && streak != STREAK_MAX) begin
            streak <= streak + 4'd1;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating counters of grants per port and of contested cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant == GNT_I && stat_i_grants != 16'hFFFF) begin
                stat_i_grants <= stat_i_grants + 16'd1;
            end
            if (grant == GNT_D && stat_d_grants != 16'hFFFF) begin
                stat_d_grants <= stat_d_grants + 16'd1;
            end
            if (i_elig && d_elig && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives the arbiter with directed scenarios and then random handshaking
// requesters. A transaction-level model (reference memory, pending acks,
// integer streak count) predicts every output each cycle. A second instance
// with MAX_D_STREAK=1 covers the forced-I case.
module tb_mem_port_arbiter;

    localparam int IDX_W = 5;
    localparam int WORDS = 1 << IDX_W;
    localparam int MAXS  = 3;

    logic              clk;
    logic              rst;
    logic              i_req, d_req, d_wen;
    logic [31:0]       i_addr, d_addr, d_wdata;
    logic              i_ack, d_ack, mem_wen;
    logic [31:0]       i_rdata, d_rdata, mem_d, mem_q;
    logic [IDX_W-1:0]  mem_a;
`ifdef ARB_STATS_EN
    logic [15:0]       stat_i_grants, stat_d_grants, stat_conflicts;
    logic [15:0]       b_unused_si, b_unused_sd, b_unused_sc;
`endif

    // Second instance: D requester tied high, I driven by the bench.
    logic              b_i_req;
    logic [31:0]       b_i_addr;
    logic              b_i_ack;
    logic [31:0]       b_i_rdata;
    logic              b_unused_d_ack, b_unused_wen;
    logic [31:0]       b_unused_d_rdata, b_unused_mem_d, b_mem_q;
    logic [IDX_W-1:0]  b_mem_a;

    // Environment memory (what the DUT really writes) and control hooks.
    logic [31:0]       env_mem [WORDS];
    logic              mem_clear, preload_en;
    logic [IDX_W-1:0]  preload_idx;
    logic [31:0]       preload_val;

    // Model state.
    logic [31:0]       ref_mem [WORDS];
    bit                live;
    bit                m_i_ack, m_d_ack;
    logic [31:0]       m_i_rdata, m_d_rdata;
    int                m_streak;
`ifdef ARB_STATS_EN
    int                m_si, m_sd, m_sc;
`endif

    int checks;
    int errors;

    mem_port_arbiter #(.IDX_W(IDX_W), .MAX_D_STREAK(MAXS)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
`ifdef ARB_STATS_EN
        , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    mem_port_arbiter #(.IDX_W(IDX_W), .MAX_D_STREAK(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(1'b1), .d_wen(1'b0), .d_addr(32'h0000_0004), .d_wdata(32'h0),
        .d_ack(b_unused_d_ack), .d_rdata(b_unused_d_rdata),
        .mem_wen(b_unused_wen), .mem_a(b_mem_a), .mem_d(b_unused_mem_d), .mem_q(b_mem_q)
`ifdef ARB_STATS_EN
        , .stat_i_grants(b_unused_si), .stat_d_grants(b_unused_sd),
        .stat_conflicts(b_unused_sc)
`endif
    );

    assign mem_q   = env_mem[mem_a];
    assign b_mem_q = 32'hC0DE_0000 | {27'b0, b_mem_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model grant decision: 0 none, 1 I, 2 D.
    function automatic int pick();
        bit ie, de;
        ie = (i_req === 1'b1) && !m_i_ack;
        de = (d_req === 1'b1) && !m_d_ack;
        if (ie && de) return (m_streak >= MAXS) ? 1 : 2;
        if (de) return 2;
        if (ie) return 1;
        return 0;
    endfunction

    function automatic bit mem_equal();
        for (int k = 0; k < WORDS; k++) begin
            if (env_mem[k] !== ref_mem[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Environment memory: writes from the DUT plus bench clear/preload.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < WORDS; k++) env_mem[k] <= '0;
        end else if (preload_en) begin
            env_mem[preload_idx] <= preload_val;
        end else if (mem_wen) begin
            env_mem[mem_a] <= mem_d;
        end
    end

    // Transaction-level model update.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < WORDS; k++) ref_mem[k] <= '0;
        end else if (preload_en) begin
            ref_mem[preload_idx] <= preload_val;
        end
        if (rst) begin
            live      <= 1'b1;
            m_i_ack   <= 1'b0;
            m_d_ack   <= 1'b0;
            m_i_rdata <= '0;
            m_d_rdata <= '0;
            m_streak  <= 0;
`ifdef ARB_STATS_EN
            m_si <= 0; m_sd <= 0; m_sc <= 0;
`endif
        end else begin
            m_i_ack <= (pick() == 1);
            m_d_ack <= (pick() == 2);
            if (pick() == 1) m_i_rdata <= ref_mem[i_addr[IDX_W+1:2]];
            if (pick() == 2) begin
                if (d_wen) begin
                    ref_mem[d_addr[IDX_W+1:2]] <= d_wdata;
                    m_d_rdata <= d_wdata;
                end else begin
                    m_d_rdata <= ref_mem[d_addr[IDX_W+1:2]];
                end
            end
            if (i_req !== 1'b1 || pick() == 1) m_streak <= 0;
            else if (pick() == 2) m_streak <= (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
`ifdef ARB_STATS_EN
            if (pick() == 1) m_si <= m_si + 1;
            if (pick() == 2) m_sd <= m_sd + 1;
            if ((i_req === 1'b1) && !m_i_ack && (d_req === 1'b1) && !m_d_ack) m_sc <= m_sc + 1;
`endif
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("i_ack", {31'b0, i_ack}, {31'b0, m_i_ack});
            check("d_ack", {31'b0, d_ack}, {31'b0, m_d_ack});
            check("i_rdata", i_rdata, m_i_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("mem_wen", {31'b0, mem_wen},
                  {31'b0, (pick() == 2) && d_wen && !rst});
            check("mem_a", {27'b0, mem_a},
                  (pick() == 2) ? {27'b0, d_addr[IDX_W+1:2]} :
                  (pick() == 1) ? {27'b0, i_addr[IDX_W+1:2]} : 32'h0);
            check("mem_d", mem_d, (pick() == 2) ? d_wdata : 32'h0);
            check("mem_contents", {31'b0, mem_equal()}, 32'h1);
`ifdef ARB_STATS_EN
            check("stat_i_grants", {16'b0, stat_i_grants}, m_si);
            check("stat_d_grants", {16'b0, stat_d_grants}, m_sd);
            check("stat_conflicts", {16'b0, stat_conflicts}, m_sc);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit seen;
        int ack_total;
        checks = 0; errors = 0;
        rst = 1'b1; mem_clear = 1'b1; preload_en = 1'b0;
        preload_idx = '0; preload_val = '0;
        i_req = 0; i_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        b_i_req = 0; b_i_addr = 0;
        cyc(); cyc();
        rst = 1'b0; mem_clear = 1'b0;
        check("rst_i_ack", {31'b0, i_ack}, 32'h0);
        check("rst_d_ack", {31'b0, d_ack}, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        // Single instruction fetch from word 3.
        preload_en = 1'b1; preload_idx = 5'd3; preload_val = 32'hDEAD_BEEF;
        cyc();
        preload_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_000C;
        cyc();
        check("fetch_ack", {31'b0, i_ack}, 32'h1);
        check("fetch_data", i_rdata, 32'hDEAD_BEEF);
        check("fetch_no_d_ack", {31'b0, d_ack}, 32'h0);
        i_req = 1'b0;
        cyc();
        check("fetch_ack_one_cycle", {31'b0, i_ack}, 32'h0);

        // Data write then read of word 4.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'h1234_5678;
        cyc();
        check("wr_ack", {31'b0, d_ack}, 32'h1);
        check("wr_echo", d_rdata, 32'h1234_5678);
        check("wr_mem4", env_mem[4], 32'h1234_5678);
        d_req = 1'b0;
        cyc();
        d_req = 1'b1; d_wen = 1'b0; d_wdata = 32'h0;
        cyc();
        check("rd_ack", {31'b0, d_ack}, 32'h1);
        check("rd_data", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        cyc();

        // Both held: grants alternate D, I, D, I ...
        i_req = 1'b1; i_addr = 32'h0000_000C; d_req = 1'b1; d_addr = 32'h0000_0010;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("alt_d_ack", {31'b0, d_ack}, (k % 2 == 1) ? 32'h1 : 32'h0);
            check("alt_i_ack", {31'b0, i_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();

        // MAX_D_STREAK=1 instance: I must be acked within two cycles.
        b_i_req = 1'b1; b_i_addr = 32'h0000_0008;
        seen = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            if (b_i_ack) seen = 1'b1;
        end
        check("streak1_i_served", {31'b0, seen}, 32'h1);
        check("streak1_i_rdata", b_i_rdata, 32'hC0DE_0002);
        b_i_req = 1'b0;

        // Reset in the same cycle as a D write grant to word 5.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0014; d_wdata = 32'hA5A5_A5A5;
        rst = 1'b1;
        #1;
        check("rst_blocks_wen", {31'b0, mem_wen}, 32'h0);
        cyc();
        rst = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        check("rst_mem5_kept", env_mem[5], 32'h0);
        check("rst_no_d_ack", {31'b0, d_ack}, 32'h0);
        check("rst_no_i_ack", {31'b0, i_ack}, 32'h0);
        check("rst_i_rdata_clr", i_rdata, 32'h0);
        check("rst_d_rdata_clr", d_rdata, 32'h0);

`ifdef ARB_STATS_EN
        // Four contested request pairs after reset.
        ack_total = 0;
        for (int r = 0; r < 4; r++) begin
            i_req = 1'b1; d_req = 1'b1;
            cyc();
            ack_total += int'(i_ack) + int'(d_ack);
            d_req = 1'b0;
            cyc();
            ack_total += int'(i_ack) + int'(d_ack);
            i_req = 1'b0;
            cyc();
            ack_total += int'(i_ack) + int'(d_ack);
        end
        check("stat_conflicts_4", {16'b0, stat_conflicts}, 32'd4);
        check("stat_ack_total_8", ack_total, 32'd8);
        check("stat_grant_sum", {16'b0, stat_i_grants} + {16'b0, stat_d_grants}, ack_total);
`else
        ack_total = 0;
`endif

        // Random handshaking requesters with occasional reset and early drops.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (i_req !== 1'b1 || i_ack) begin
                i_req  = ($urandom_range(0, 9) < 6);
                i_addr = $urandom;
            end else if ($urandom_range(0, 63) == 0) begin
                i_req = 1'b0;
            end
            if (d_req !== 1'b1 || d_ack) begin
                d_req   = ($urandom_range(0, 9) < 6);
                d_wen   = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 63) == 0) begin
                d_req = 1'b0;
            end
            rst = ($urandom_range(0, 199) == 0);
            if (i_ack || d_ack) ack_total++;
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
